// File: rtl/display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_7seg
// Brief    : 10-bit binary to 4-digit BCD (double-dabble) with multiplexed
//            common-anode 7-segment scan and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_7seg #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] valor,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       done
);

    localparam int                   C_PRESC_W    = $clog2(SCAN_DIV);
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(SCAN_DIV - 1);
    localparam logic [3:0]           C_LAST_BIT   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_capture;
    logic   w_shift_en;
    logic   w_load;

    logic [9:0]  r_shift;
    logic [15:0] r_scratch;
    logic [15:0] w_adj;
    logic [3:0]  r_bitcnt;
    logic [15:0] r_bcd_q;
    logic        r_done;

    logic [C_PRESC_W-1:0] r_presc;
    logic                 w_tick;
    logic [1:0]           r_idx;

    logic [3:0] w_digit;
    logic [3:0] w_blank;
    logic [3:0] w_an_nxt;
    logic [6:0] w_seg_nxt;
    logic [3:0] r_an;
    logic [6:0] r_seg;

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_CONV;
            end
            S_CONV: begin
                w_shift_en = 1'b1;
                if (r_bitcnt == C_LAST_BIT) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Each nibble is corrected independently; no carry crosses nibble borders.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_nib
            assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5)
                                   ? (r_scratch[4*i +: 4] + 4'd3)
                                   : r_scratch[4*i +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_bitcnt  <= '0;
            r_bcd_q   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_capture) begin
                r_shift   <= valor;
                r_scratch <= '0;
                r_bitcnt  <= '0;
            end
            if (w_shift_en) begin
                {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                r_bitcnt             <= r_bitcnt + 4'd1;
            end
            if (w_load) begin
                r_bcd_q <= r_scratch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == C_PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + {{(C_PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Digit select, blanking and segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        w_digit    = 4'd0;
        w_blank    = 4'b0000;
        w_an_nxt   = 4'b1111;
        w_seg_nxt  = 7'b1111111;

        case (r_idx)
            2'd0:    w_digit = r_bcd_q[3:0];
            2'd1:    w_digit = r_bcd_q[7:4];
            2'd2:    w_digit = r_bcd_q[11:8];
            default: w_digit = r_bcd_q[15:12];
        endcase

        // A slot is blank only if it and every more-significant digit are zero.
        w_blank[3] = (r_bcd_q[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd_q[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd_q[7:4] == 4'd0);
        w_blank[0] = 1'b0;

        if (!w_blank[r_idx]) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = seg_decode(w_digit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_7seg
// Brief    : Directed self-checking bench for display_scan_7seg (SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_7seg;

    logic       clk;
    logic       rst_n;
    logic [9:0] valor;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       done;

    int total = 0;
    int bad   = 0;
    int ecount;

    display_scan_7seg #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valor (valor),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; slot shown after edge n is ((n-1)/4)%4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        bit found;
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, found}, 32'd1);
    endtask

    // ans/segs hold slot3..slot0 packed from MSB to LSB.
    task automatic scan_check(input string tag, input logic [15:0] ans, input logic [27:0] segs);
        int s;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            s = ((ecount - 1) / 4) % 4;
            chk({tag, "_an"},  {28'd0, an},  {28'd0, ans[s*4 +: 4]});
            chk({tag, "_seg"}, {25'd0, seg}, {25'd0, segs[s*7 +: 7]});
        end
    endtask

    initial begin
        int          n;
        logic [15:0] b;
        logic [15:0] e;

        // Reset state
        rst_n = 1'b0;
        valor = 10'd1023;
        repeat (3) @(negedge clk);
        chk("rst_an",   {28'd0, an},   32'hF);
        chk("rst_seg",  {25'd0, seg},  32'h7F);
        chk("rst_dp",   {31'd0, dp},   32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd",  {16'd0, dut.r_bcd_q}, 32'h0);

        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_an",  {28'd0, an},  32'b1110);
        chk("first_seg", {25'd0, seg}, 32'b1000000);

        // Full scale
        wait_done(n);
        chk("lat_first", n + 1, 32'd12);
        chk("bcd_1023a", {16'd0, dut.r_bcd_q}, 32'h1023);
        wait_done(n);
        chk("period_1023", n, 32'd12);
        chk("bcd_1023b", {16'd0, dut.r_bcd_q}, 32'h1023);
        scan_check("s1023", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});

        // Blanking
        valor = 10'd7;
        wait_done(n);
        wait_done(n);
        chk("bcd_7", {16'd0, dut.r_bcd_q}, 32'h0007);
        scan_check("s7", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});

        valor = 10'd100;
        wait_done(n);
        wait_done(n);
        chk("bcd_100", {16'd0, dut.r_bcd_q}, 32'h0100);
        scan_check("s100", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});

        // Change during conversion is ignored until the next capture
        wait_done(n);
        valor = 10'd512;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        valor = 10'd45;
        wait_done(n);
        chk("mid_lat", n, 32'd8);
        chk("mid_bcd512", {16'd0, dut.r_bcd_q}, 32'h0512);
        wait_done(n);
        chk("mid_period", n, 32'd12);
        chk("mid_bcd45", {16'd0, dut.r_bcd_q}, 32'h0045);

        // Reset during conversion
        valor = 10'd999;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_an",   {28'd0, an},   32'hF);
        chk("mrst_seg",  {25'd0, seg},  32'h7F);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_bcd",  {16'd0, dut.r_bcd_q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(n);
        chk("mrst_lat", n, 32'd12);
        chk("mrst_bcd999", {16'd0, dut.r_bcd_q}, 32'h0999);

        // Exhaustive sweep, two conversions per value
        for (int v = 0; v < 1024; v++) begin
            valor = 10'(v);
            e = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            for (int r = 0; r < 2; r++) begin
                wait_done(n);
                b = dut.r_bcd_q;
                chk("sweep_bcd", {16'd0, b}, {16'd0, e});
                chk("sweep_nib",
                    {31'd0, (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) &&
                            (b[11:8] <= 4'd9) && (b[15:12] <= 4'd9)},
                    32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
